camera_pattern_source: RTL and testbench
========================================

Name: camera_pattern_source

Overview:
- Synthesizable OV7670-style video source on the 48 MHz system clock.
- Drives PCLK/VSYNC/HREF/D[7:0] with the same polarity and timing the capture path expects: VSYNC high = idle, VSYNC low = active frame, HREF high = valid bytes.
- Loops back into the capture/threshold path on-board, or stands in for the camera, for bring-up without a sensor.
- Emits YUV422-style byte pairs (Y, then chroma 0x80) carrying selectable test patterns.

Parameters:
PCLK_HALF, 12, clk cycles per PCLK half-period (12 gives 2 MHz PCLK at 48 MHz); must be >= 2
H_ACTIVE, 640, bytes per line with HREF high (320 pixels x 2 bytes); must be even
H_BLANK, 144, PCLK cycles of HREF low after each line
V_ACTIVE, 240, active lines per frame
VSYNC_LINES, 3, lines with VSYNC high at frame start
VBP_LINES, 17, lines after VSYNC falls before the first active line
VFP_LINES, 10, lines after the last active line
LINE_W, 16, dark-line width in pixels for pattern 0

Ports:
clk  input  1  system clock, 48 MHz
nreset  input  1  asynchronous active-low reset
enable  input  1  run frames; sampled only at frame boundaries
pattern_sel  input  2  0 dark vertical line, 1 horizontal gradient, 2 checker, 3 all black
line_pos  input  9  left pixel column of the pattern-0 line
cam_pclk  output  1  generated pixel clock
cam_vsync  output  1  frame sync, high = idle
cam_href  output  1  line valid
cam_data  output  8  pixel byte
frame_done  output  1  one-clk pulse at the end of each active region
frame_count  output  16  completed frames, wraps 0xFFFF->0x0000
busy  output  1  high from leaving IDLE until return to IDLE

Behaviour:
- Reset (async assert, sync release): cam_pclk=0, cam_vsync=1, cam_href=0, cam_data=0x00, frame_done=0, frame_count=0, busy=0, state IDLE. All counters clear.
- PCLK generation:
  - Divider counts 0..PCLK_HALF-1 and toggles cam_pclk on wrap. It runs freely whenever out of reset, independent of enable.
  - A "fall tick" is the clk on which cam_pclk toggles 1->0.
  - All other outputs and state/counter updates change only on fall ticks, so data is stable across each PCLK rising edge.
- Counters:
  - Byte counter runs 0..H_ACTIVE+H_BLANK-1. Line counter counts lines within the current state.
  - Both advance on fall ticks in every state except IDLE.
- States:
  - IDLE: vsync=1, href=0, data=0. On a fall tick with enable=1: latch pattern_sel and line_pos into shadow registers, enter VSYNC, set busy=1.
  - VSYNC: vsync=1 for VSYNC_LINES lines, then VBP.
  - VBP: vsync=0, href=0 for VBP_LINES lines, then ACTIVE.
  - ACTIVE: vsync=0 for V_ACTIVE lines.
    - href=1 while byte counter < H_ACTIVE, else 0.
    - data valid only while href=1; forced 0x00 when href=0.
  - VFP: vsync=0, href=0 for VFP_LINES lines. At the end, if enable=1, re-latch shadows and enter VSYNC; otherwise enter IDLE and clear busy.
- Frame completion: on the fall tick leaving ACTIVE for VFP, pulse frame_done for exactly one clk and increment frame_count.
- Byte content (x = byte_counter>>1, y = active line index):
  - Odd bytes are 0x80.
  - Even bytes (Y) by pattern:
    - 0: 0x10 if line_pos <= x < line_pos+LINE_W, else 0xE0. Columns past 319 are simply not drawn, so there is no wrap.
    - 1: x[8:1].
    - 2: (x[4]^y[4]) ? 0xE0 : 0x10.
    - 3: 0x10.
- Changes to pattern_sel or line_pos mid-frame have no effect until the next frame latch.
- enable deasserted mid-frame: the current frame completes through VFP, then the block enters IDLE. It never truncates a frame.
- nreset asserted mid-frame: outputs return to reset values immediately and frame_count clears.
- Derived frame length (non-IDLE): (VSYNC_LINES+VBP_LINES+V_ACTIVE+VFP_LINES) x (H_ACTIVE+H_BLANK) PCLK cycles.

Test Plan:
- Reset/idle: hold nreset=0 for 10 clk, then release with enable=0 for 1000 clk -> vsync=1, href=0, data=0, busy=0. cam_pclk period is exactly 24 clk with 50% duty.
- Timing (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, PCLK_HALF=2), enable=1 -> per frame:
  - vsync high for 12 PCLKs;
  - exactly 4 href pulses of 8 PCLKs, separated by 4 low PCLKs;
  - frame period 84 PCLKs = 336 clk;
  - frame_done pulses once per frame, one clk wide; frame_count increments.
- Pattern 0 with line_pos=100 at default sizes -> on every active line, Y bytes at x=99 and x=116 are 0xE0, Y at x=100..115 is 0x10, all odd bytes are 0x80. Changing line_pos to 200 mid-frame has no effect until the next frame.
- Capture alignment: sample cam_data/cam_href on every cam_pclk rising edge -> values never change within PCLK_HALF clk of that edge. The checker-pattern frame reproduces exactly (x[4]^y[4]).
- Drop enable halfway through ACTIVE -> the remaining active lines and VFP are still emitted, frame_done fires once, then IDLE with vsync=1 and busy=0.
- Assert nreset during the ACTIVE line 10 -> outputs return to reset values within the same clk. After release with enable=1, the next frame starts from VSYNC with frame_count=0 then 1.

Source files
------------

// File: rtl/camera_pattern_source.sv
// rtl/camera_pattern_source.sv - OV7670-style PCLK/VSYNC/HREF/D test-pattern video source
module camera_pattern_source #(
  parameter int PCLK_HALF   = 12,
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int LINE_W      = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [8:0]  line_pos,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int BW      = $clog2(H_TOTAL + 1);
  localparam int LW      = $clog2(VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);
  localparam int DW      = $clog2(PCLK_HALF + 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d, last_line;
  logic [1:0]    pat_q, pat_d;
  logic [8:0]    lpos_q, lpos_d;
  logic          vsync_q, vsync_d, href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d, busy_q, busy_d;
  logic [15:0]   count_q, count_d;
  logic          div_wrap, fall_tick;

  function automatic logic [7:0] pixel_byte(input logic [BW-1:0] b, input logic [LW-1:0] y,
                                            input logic [1:0] pat, input logic [8:0] lp);
    logic [8:0] x;
    logic       in_line, y4;
    x       = 9'(b >> 1);
    in_line = ({1'b0, x} >= {1'b0, lp}) && ({1'b0, x} < ({1'b0, lp} + 10'(LINE_W)));
    y4      = ((int'(y) / 16) % 2) == 1;
    if (b[0]) return 8'h80;
    case (pat)
      2'd0:    return in_line ? 8'h10 : 8'hE0;
      2'd1:    return x[8:1];
      2'd2:    return (x[4] ^ y4) ? 8'hE0 : 8'h10;
      default: return 8'h10;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      S_VBP:    last_line = LW'(VBP_LINES - 1);
      S_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      default:  last_line = LW'(VFP_LINES - 1);
    endcase
  end

  assign div_wrap  = (div_q == DW'(PCLK_HALF - 1));
  assign fall_tick = div_wrap && pclk_q;

  always_comb begin
    div_d   = div_wrap ? '0 : div_q + DW'(1);
    pclk_d  = div_wrap ? ~pclk_q : pclk_q;
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    pat_d   = pat_q;
    lpos_d  = lpos_q;
    busy_d  = busy_q;
    count_d = count_q;
    done_d  = 1'b0;
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (fall_tick) begin
      if (state_q == S_IDLE) begin
        if (enable) begin
          state_d = S_VSYNC;
          pat_d   = pattern_sel;
          lpos_d  = line_pos;
          busy_d  = 1'b1;
          byte_d  = '0;
          line_d  = '0;
        end
      end else if (byte_q != BW'(H_TOTAL - 1)) begin
        byte_d = byte_q + BW'(1);
      end else begin
        byte_d = '0;
        if (line_q != last_line) begin
          line_d = line_q + LW'(1);
        end else begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBP;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: begin
              state_d = S_VFP;
              done_d  = 1'b1;
              count_d = count_q + 16'd1;
            end
            default: begin
              // Frame boundary: the only point besides IDLE where enable is honoured.
              if (enable) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel;
                lpos_d  = line_pos;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end
          endcase
        end
      end
      vsync_d = (state_d == S_IDLE) || (state_d == S_VSYNC);
      href_d  = (state_d == S_ACTIVE) && (byte_d < BW'(H_ACTIVE));
      data_d  = href_d ? pixel_byte(byte_d, line_d, pat_d, lpos_d) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      byte_q  <= '0;
      line_q  <= '0;
      pat_q   <= 2'd0;
      lpos_q  <= 9'd0;
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      lpos_q  <= lpos_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign cam_pclk    = pclk_q;
  assign cam_vsync   = vsync_q;
  assign cam_href    = href_q;
  assign cam_data    = data_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_camera_pattern_source.sv
// tb/tb_camera_pattern_source.sv - directed bench for camera_pattern_source
module tb_camera_pattern_source;

  localparam int PCLK_HALF = 2, H_ACTIVE = 240, H_BLANK = 4, V_ACTIVE = 20;
  localparam int VSYNC_LINES = 1, VBP_LINES = 1, VFP_LINES = 1, LINE_W = 16;
  localparam int CLK_T = 10;
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int FRAME_CLK = (VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES) * H_TOTAL * 2 * PCLK_HALF;

  logic clk = 1'b0, nreset = 1'b0, enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [8:0] line_pos = 9'd0;
  logic cam_pclk, cam_vsync, cam_href, frame_done, busy;
  logic [7:0] cam_data;
  logic [15:0] frame_count;

  camera_pattern_source #(
    .PCLK_HALF(PCLK_HALF), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES), .LINE_W(LINE_W)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .pattern_sel(pattern_sel), .line_pos(line_pos),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  always #(CLK_T / 2) clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc_cnt = 0, done_pulses = 0;
  int exp_pat = 0, exp_lp = 0;
  int line_idx = 0, byte_idx = 0, run = 0, href_rises = 0, bad_pulse = 0, bad_gap = 0;
  int vs_hi = 0, byte_checks = 0, byte_errs = 0, low_err = 0, stab_err = 0;
  logic prev_href = 1'b0;
  logic [7:0] cap_y [0:127];
  time last_chg = 0, last_rise = 0;

  function automatic logic [7:0] exp_byte(input int b, input int y, input int pat, input int lp);
    int x;
    if (b % 2 == 1) return 8'h80;
    x = b / 2;
    case (pat)
      0: return (x >= lp && x < lp + LINE_W) ? 8'h10 : 8'hE0;
      1: return 8'((x / 2) % 256);
      2: return ((((x / 16) ^ (y / 16)) % 2) == 1) ? 8'hE0 : 8'h10;
      default: return 8'h10;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    line_idx = 0; byte_idx = 0; run = 0; href_rises = 0; bad_pulse = 0; bad_gap = 0;
    vs_hi = 0; byte_checks = 0; byte_errs = 0; low_err = 0; stab_err = 0; prev_href = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc_cnt++;
    if (frame_done) done_pulses++;
  end

  always @(cam_data or cam_href) begin
    if (busy && ($time - last_rise) < PCLK_HALF * CLK_T) stab_err++;
    last_chg = $time;
  end

  // Capture-side model: samples like the real capture path on each PCLK rise.
  always @(posedge cam_pclk) begin
    if (busy && ($time - last_chg) < PCLK_HALF * CLK_T) stab_err++;
    last_rise = $time;
    #1;
    if (cam_vsync) line_idx = 0;
    if (cam_vsync && busy) vs_hi++;
    if (cam_href != prev_href) begin
      if (prev_href && run != H_ACTIVE) bad_pulse++;
      if (!prev_href && line_idx > 0 && run != H_BLANK) bad_gap++;
      if (prev_href) line_idx++;
      else href_rises++;
      run = 0;
      byte_idx = 0;
    end
    run++;
    if (cam_href) begin
      byte_checks++;
      if (cam_data !== exp_byte(byte_idx, line_idx, exp_pat, exp_lp)) byte_errs++;
      if (byte_idx % 2 == 0 && byte_idx / 2 < 128) cap_y[byte_idx / 2] = cam_data;
      byte_idx++;
    end else if (busy && cam_data !== 8'h00) begin
      low_err++;
    end
    prev_href = cam_href;
  end

  initial begin
    #(1_500_000 * CLK_T / 10);
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_busy(input logic level, output bit ok);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (busy === level) ok = 1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < FRAME_CLK + 1000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) ok = 1;
    end
  endtask

  task automatic wait_line(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < FRAME_CLK + 1000 && !ok; i++) begin
      @(negedge clk);
      if (line_idx == n && cam_href === 1'b1) ok = 1;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_href_pulses"}, href_rises, V_ACTIVE);
    check({tag, "_bad_pulse_len"}, bad_pulse, 0);
    check({tag, "_bad_gap_len"}, bad_gap, 0);
    check({tag, "_byte_checks"}, byte_checks, V_ACTIVE * H_ACTIVE);
    check({tag, "_byte_errs"}, byte_errs, 0);
    check({tag, "_vsync_hi_pclks"}, vs_hi, VSYNC_LINES * H_TOTAL);
    check({tag, "_data_nonzero_href_low"}, low_err, 0);
    check({tag, "_stability"}, stab_err, 0);
  endtask

  initial begin
    bit ok;
    int t1, t2, idle_err, hi_cnt, lo_cnt;

    repeat (10) @(negedge clk);
    check("rst_pclk", cam_pclk, 0);
    check("rst_vsync", cam_vsync, 1);
    check("rst_href", cam_href, 0);
    check("rst_data", cam_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_count", frame_count, 0);
    check("rst_busy", busy, 0);

    nreset = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cam_vsync !== 1'b1 || cam_href !== 1'b0 || cam_data !== 8'h00 || busy !== 1'b0) idle_err++;
    end
    check("idle_outputs", idle_err, 0);
    for (int i = 0; i < 20 && cam_pclk !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 20 && cam_pclk !== 1'b1; i++) @(negedge clk);
    hi_cnt = 0; lo_cnt = 0;
    for (int i = 0; i < 20 && cam_pclk === 1'b1; i++) begin hi_cnt++; @(negedge clk); end
    for (int i = 0; i < 20 && cam_pclk === 1'b0; i++) begin lo_cnt++; @(negedge clk); end
    check("pclk_high_clks", hi_cnt, PCLK_HALF);
    check("pclk_low_clks", lo_cnt, PCLK_HALF);

    // Frame 1: pattern 0 at column 100; inputs changed mid-frame must not show.
    clear_stats();
    exp_pat = 0; exp_lp = 100;
    pattern_sel = 2'd0; line_pos = 9'd100; enable = 1'b1;
    wait_busy(1'b1, ok);
    check("f1_busy_timeout", ok, 1);
    check("f1_vsync_at_start", cam_vsync, 1);
    wait_line(10, ok);
    check("f1_line10_timeout", ok, 1);
    pattern_sel = 2'd2; line_pos = 9'd50;
    wait_done(ok);
    check("f1_done_timeout", ok, 1);
    t1 = cyc_cnt;
    check("f1_count", frame_count, 1);
    check_frame("f1");
    check("f1_y99", cap_y[99], 8'hE0);
    check("f1_y100", cap_y[100], 8'h10);
    check("f1_y115", cap_y[115], 8'h10);
    check("f1_y116", cap_y[116], 8'hE0);
    @(negedge clk);
    check("f1_done_width", frame_done, 0);

    // Frame 2: checker latched at the frame boundary; enable drops mid-ACTIVE.
    clear_stats();
    exp_pat = 2; exp_lp = 50;
    wait_line(10, ok);
    check("f2_line10_timeout", ok, 1);
    enable = 1'b0;
    wait_done(ok);
    check("f2_done_timeout", ok, 1);
    t2 = cyc_cnt;
    check("frame_period_clks", t2 - t1, FRAME_CLK);
    check("f2_count", frame_count, 2);
    check_frame("f2");
    check("f2_y0_line19", cap_y[0], 8'hE0);
    check("f2_y16_line19", cap_y[16], 8'h10);
    check("f2_busy_in_vfp", busy, 1);
    wait_busy(1'b0, ok);
    check("f2_idle_timeout", ok, 1);
    check("f2_idle_vsync", cam_vsync, 1);
    repeat (100) @(negedge clk);
    check("f2_stays_idle", busy, 0);
    check("done_pulses_after_f2", done_pulses, 2);

    // Frame 3: gradient, interrupted by reset during active line 10.
    exp_pat = 1; exp_lp = 50;
    pattern_sel = 2'd1; enable = 1'b1;
    wait_line(10, ok);
    check("f3_line10_timeout", ok, 1);
    nreset = 1'b0;
    #1;
    check("midrst_pclk", cam_pclk, 0);
    check("midrst_vsync", cam_vsync, 1);
    check("midrst_href", cam_href, 0);
    check("midrst_data", cam_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", frame_count, 0);
    clear_stats();
    repeat (5) @(negedge clk);
    nreset = 1'b1;

    // Frame 4: full gradient frame after reset.
    wait_busy(1'b1, ok);
    check("f4_busy_timeout", ok, 1);
    check("f4_count_start", frame_count, 0);
    wait_done(ok);
    check("f4_done_timeout", ok, 1);
    check("f4_count", frame_count, 1);
    check_frame("f4");
    check("f4_y2", cap_y[2], 8'h01);
    check("f4_y119", cap_y[119], 8'h3B);
    enable = 1'b0;
    wait_busy(1'b0, ok);
    check("f4_idle_timeout", ok, 1);
    check("done_pulses_total", done_pulses, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
